// File: rtl/operand_forward_wb.sv
`default_nettype none
// ============================================================================
//  Module   : operand_forward_wb
//  Purpose  : ID register-file read, ID/EX operand latch, EX operand
//             forwarding and EX/MEM -> MEM/WB -> regfile writeback for the
//             8-bit mov/add pipeline. Option macro: FORWARD_EN (bypass muxes
//             enabled, no stalls); undefined -> stall-on-hazard, no bypass.
//  Revision : 1.0  initial release
// ============================================================================
module operand_forward_wb #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Valid_ID,
    input  logic [REG_AW-1:0] Rs1_Addr_ID,
    input  logic [REG_AW-1:0] Rs2_Addr_ID,
    input  logic [REG_AW-1:0] Rd_Addr_ID,
    input  logic              Reg_Write_ID,
    input  logic [DATA_W-1:0] ALU_Result,
    output logic [DATA_W-1:0] Data1_Final,
    output logic [DATA_W-1:0] Data2_Final,
    output logic              Stall,
    output logic              WB_En,
    output logic [REG_AW-1:0] WB_Addr,
    output logic [DATA_W-1:0] WB_Data
);

    localparam int c_NUM_REGS = 2 ** REG_AW;

    logic [DATA_W-1:0] r_regs [c_NUM_REGS];

    // ID/EX
    logic              r_ie_v;
    logic [REG_AW-1:0] r_ie_rd;
    logic              r_ie_we;
    logic [DATA_W-1:0] r_ie_d1;
    logic [DATA_W-1:0] r_ie_d2;
`ifdef FORWARD_EN
    logic [REG_AW-1:0] r_ie_rs1;
    logic [REG_AW-1:0] r_ie_rs2;
`endif
    // EX/MEM
    logic              r_em_v;
    logic [REG_AW-1:0] r_em_rd;
    logic              r_em_we;
    logic [DATA_W-1:0] r_em_res;
    // MEM/WB
    logic              r_mw_v;
    logic [REG_AW-1:0] r_mw_rd;
    logic              r_mw_we;
    logic [DATA_W-1:0] r_mw_res;

    logic              w_em_eff;
    logic              w_mw_eff;
    logic              w_stall;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_em_eff = r_em_v & r_em_we & (r_em_rd != '0);
    assign w_mw_eff = r_mw_v & r_mw_we & (r_mw_rd != '0);

    // Write-through read: a same-cycle writeback to the addressed register wins
    always_comb begin
        w_rd1 = r_regs[Rs1_Addr_ID];
        w_rd2 = r_regs[Rs2_Addr_ID];
        if (Rs1_Addr_ID == '0)
            w_rd1 = '0;
        else if (w_mw_eff && (r_mw_rd == Rs1_Addr_ID))
            w_rd1 = r_mw_res;
        if (Rs2_Addr_ID == '0)
            w_rd2 = '0;
        else if (w_mw_eff && (r_mw_rd == Rs2_Addr_ID))
            w_rd2 = r_mw_res;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < c_NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (w_mw_eff) begin
            r_regs[r_mw_rd] <= r_mw_res;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ie_v   <= 1'b0;
            r_ie_rd  <= '0;
            r_ie_we  <= 1'b0;
            r_ie_d1  <= '0;
            r_ie_d2  <= '0;
`ifdef FORWARD_EN
            r_ie_rs1 <= '0;
            r_ie_rs2 <= '0;
`endif
            r_em_v   <= 1'b0;
            r_em_rd  <= '0;
            r_em_we  <= 1'b0;
            r_em_res <= '0;
            r_mw_v   <= 1'b0;
            r_mw_rd  <= '0;
            r_mw_we  <= 1'b0;
            r_mw_res <= '0;
        end else begin
            r_ie_v   <= Valid_ID & ~w_stall;
            r_ie_rd  <= Rd_Addr_ID;
            r_ie_we  <= Reg_Write_ID;
            r_ie_d1  <= w_rd1;
            r_ie_d2  <= w_rd2;
`ifdef FORWARD_EN
            r_ie_rs1 <= Rs1_Addr_ID;
            r_ie_rs2 <= Rs2_Addr_ID;
`endif
            r_em_v   <= r_ie_v;
            r_em_rd  <= r_ie_rd;
            r_em_we  <= r_ie_we;
            r_em_res <= ALU_Result;
            r_mw_v   <= r_em_v;
            r_mw_rd  <= r_em_rd;
            r_mw_we  <= r_em_we;
            r_mw_res <= r_em_res;
        end
    end

`ifdef FORWARD_EN
    // Youngest producer (EX/MEM) takes priority over MEM/WB
    always_comb begin
        Data1_Final = r_ie_d1;
        Data2_Final = r_ie_d2;
        if (w_em_eff && (r_em_rd == r_ie_rs1))
            Data1_Final = r_em_res;
        else if (w_mw_eff && (r_mw_rd == r_ie_rs1))
            Data1_Final = r_mw_res;
        if (w_em_eff && (r_em_rd == r_ie_rs2))
            Data2_Final = r_em_res;
        else if (w_mw_eff && (r_mw_rd == r_ie_rs2))
            Data2_Final = r_mw_res;
    end

    assign w_stall = 1'b0;
`else
    logic w_ie_eff;
    logic w_hit1;
    logic w_hit2;

    assign w_ie_eff = r_ie_v & r_ie_we & (r_ie_rd != '0);

    // MEM/WB producers are covered by the write-through read, so never stall on them
    assign w_hit1 = (Rs1_Addr_ID != '0) &
                    ((w_ie_eff & (r_ie_rd == Rs1_Addr_ID)) |
                     (w_em_eff & (r_em_rd == Rs1_Addr_ID)));
    assign w_hit2 = (Rs2_Addr_ID != '0) &
                    ((w_ie_eff & (r_ie_rd == Rs2_Addr_ID)) |
                     (w_em_eff & (r_em_rd == Rs2_Addr_ID)));

    assign w_stall     = Valid_ID & (w_hit1 | w_hit2);
    assign Data1_Final = r_ie_d1;
    assign Data2_Final = r_ie_d2;
`endif

    assign Stall   = w_stall;
    assign WB_En   = w_mw_eff;
    assign WB_Addr = r_mw_rd;
    assign WB_Data = r_mw_res;

endmodule
`default_nettype wire
